// File: rtl/proc_seq_pkg.sv
// Shared types and constants for the processor sequencer.
// Holds the FSM state encoding, the error-code enum and the PC step size.
package proc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    HK_NONE    = 2'd0,
    HK_DECODE  = 2'd1,
    HK_EXECUTE = 2'd2,
    HK_TIMEOUT = 2'd3
  } hata_kod_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_timer.sv
// Fetch wait-cycle counter with clear/enable.
// `timeout` is high while the count sits at FETCH_TIMEOUT-1, i.e. during the
// last FETCH cycle the sequencer may still accept an ack; FETCH_TIMEOUT >= 1.
module fetch_timer #(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned CNT_W = $clog2(FETCH_TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  // Count unacknowledged FETCH cycles; clear has priority over enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign timeout = (count_q == CNT_W'(FETCH_TIMEOUT - 1));

endmodule

// File: rtl/processor_sequencer.sv
// Multi-cycle control FSM: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// owning the PC and the instruction register, halting stickily on any error.
// Optional build macro PROC_SEQ_PERF_EN adds `retired`/`stall_cycles` counters.
module processor_sequencer
  import proc_seq_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] PC_RESET      = '0,
  parameter int unsigned     FETCH_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     komut,
  input  logic            decode_hata,
  output logic            ex_en,
  input  logic            execute_hata,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] pc_update,
  output logic            we,
  output logic [XLEN-1:0] pc,
  output logic            busy,
  output logic            hata,
  output logic [1:0]      hata_kod
`ifdef PROC_SEQ_PERF_EN
  ,
  output logic [31:0]     retired,
  output logic [31:0]     stall_cycles
`endif
);

  state_t          state_q, state_d;
  hata_kod_t       hata_kod_q, hata_kod_d;
  logic [XLEN-1:0] pc_q, npc_q;
  logic [31:0]     komut_q;
  logic            fetch_wait;
  logic            timeout;

  // A FETCH cycle without ack is a wait cycle; anything else restarts the timer.
  assign fetch_wait = (state_q == ST_FETCH) && !imem_ack;

  fetch_timer #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!fetch_wait),
    .enable (fetch_wait),
    .timeout(timeout)
  );

  // State and error-code registers; hata_kod only changes on entry to HALT.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q    <= ST_IDLE;
      hata_kod_q <= HK_NONE;
    end else begin
      state_q    <= state_d;
      hata_kod_q <= hata_kod_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    hata_kod_d = hata_kod_q;
    imem_req   = 1'b0;
    ex_en      = 1'b0;
    we         = 1'b0;
    busy       = 1'b1;
    hata       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        // An ack in the timeout cycle still completes the fetch.
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d    = ST_HALT;
          hata_kod_d = HK_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (decode_hata) begin
          state_d    = ST_HALT;
          hata_kod_d = HK_DECODE;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        ex_en = 1'b1;
        // Misaligned branch targets fault like an execute error.
        if (execute_hata || (branch_taken && (pc_update[1:0] != 2'b00))) begin
          state_d    = ST_HALT;
          hata_kod_d = HK_EXECUTE;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        we      = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        busy = 1'b0;
        hata = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: instruction latch, next-PC staging and the PC itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= PC_RESET;
      npc_q   <= PC_RESET;
      komut_q <= '0;
    end else begin
      if ((state_q == ST_FETCH) && imem_ack) komut_q <= imem_rdata;
      if (state_q == ST_EXECUTE) npc_q <= branch_taken ? pc_update : pc_q + XLEN'(PC_STEP);
      if (state_q == ST_WRITEBACK) pc_q <= npc_q;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign komut     = komut_q;
  assign hata_kod  = hata_kod_q;

`ifdef PROC_SEQ_PERF_EN
  logic [31:0] retired_q, stall_q;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state_q == ST_WRITEBACK) retired_q <= retired_q + 32'd1;
      if (fetch_wait) stall_q <= stall_q + 32'd1;
    end
  end

  assign retired      = retired_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_processor_sequencer.sv
// Self-checking bench for processor_sequencer. Inputs change on the falling
// edge and outputs are sampled there; a per-instruction model tracks the
// expected PC, instruction register, error code and performance counts.
module tb_processor_sequencer;

  localparam int FT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        decode_hata = 1'b0;
  logic        execute_hata = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] pc_update = '0;
  logic        imem_req, ex_en, we, busy, hata;
  logic [31:0] imem_addr, komut, pc;
  logic [1:0]  hata_kod;

  logic        w_start = 1'b0;
  logic        w_ack = 1'b0;
  logic        w_req, w_ex_en, w_we, w_busy, w_hata;
  logic [31:0] w_addr, w_komut, w_pc;
  logic [1:0]  w_kod;

`ifdef PROC_SEQ_PERF_EN
  logic [31:0] retired, stall_cycles, w_retired, w_stall;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_pc, m_komut;
  int          m_retired, m_stalls;

  processor_sequencer #(
    .XLEN(32), .PC_RESET(32'h0000_0000), .FETCH_TIMEOUT(FT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .komut(komut), .decode_hata(decode_hata),
    .ex_en(ex_en), .execute_hata(execute_hata), .branch_taken(branch_taken),
    .pc_update(pc_update), .we(we), .pc(pc), .busy(busy), .hata(hata),
    .hata_kod(hata_kod)
`ifdef PROC_SEQ_PERF_EN
    , .retired(retired), .stall_cycles(stall_cycles)
`endif
  );

  processor_sequencer #(
    .XLEN(32), .PC_RESET(32'hFFFF_FFFC), .FETCH_TIMEOUT(FT)
  ) dut_wrap (
    .clk(clk), .reset(reset), .start(w_start),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(32'h1234_5678), .komut(w_komut), .decode_hata(1'b0),
    .ex_en(w_ex_en), .execute_hata(1'b0), .branch_taken(1'b0),
    .pc_update(32'h0), .we(w_we), .pc(w_pc), .busy(w_busy), .hata(w_hata),
    .hata_kod(w_kod)
`ifdef PROC_SEQ_PERF_EN
    , .retired(w_retired), .stall_cycles(w_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef PROC_SEQ_PERF_EN
    check({tag, "_retired"}, retired, 32'(m_retired));
    check({tag, "_stalls"}, stall_cycles, 32'(m_stalls));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_komut = 32'h0; m_retired = 0; m_stalls = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_komut"}, komut, 32'h0);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_ex_en"}, 32'(ex_en), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hata"}, 32'(hata), 32'd0);
    check({tag, "_kod"}, 32'(hata_kod), 32'd0);
    check_perf(tag);
  endtask

  // Called at a falling edge: assert reset, check, release at the next one.
  task automatic do_reset();
    reset = 1'b0; start = 1'b0; imem_ack = 1'b0; decode_hata = 1'b0;
    execute_hata = 1'b0; branch_taken = 1'b0; w_start = 1'b0; w_ack = 1'b0;
    model_reset();
    #1;
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // First cycle in HALT: check state, then show start/ack have no effect.
  task automatic check_halt(input logic [1:0] kod);
    check("halt_hata", 32'(hata), 32'd1);
    check("halt_kod", 32'(hata_kod), 32'(kod));
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_we", 32'(we), 32'd0);
    check("halt_ex_en", 32'(ex_en), 32'd0);
    check("halt_pc", pc, m_pc);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; imem_ack = 1'b1; imem_rdata = $urandom;
      @(negedge clk);
      check("halt_sticky_hata", 32'(hata), 32'd1);
      check("halt_sticky_kod", 32'(hata_kod), 32'(kod));
      check("halt_sticky_pc", pc, m_pc);
      check("halt_sticky_komut", komut, m_komut);
      check("halt_sticky_busy", 32'(busy), 32'd0);
      check("halt_sticky_we", 32'(we), 32'd0);
    end
    start = 1'b0; imem_ack = 1'b0;
    check_perf("halt");
  endtask

  // Called at a falling edge inside the first FETCH cycle of an instruction.
  // w = wait cycles before ack (w >= FT means the fetch never completes).
  task automatic run_instr(input int w, input logic [31:0] instr, input logic dec_e,
                           input logic ex_e, input logic br, input logic [31:0] tgt,
                           input logic abort_ex);
    int cyc = 0;
    for (int k = 0; k < FT; k++) begin
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_addr", imem_addr, m_pc);
      check("fetch_busy", 32'(busy), 32'd1);
      check("fetch_we", 32'(we), 32'd0);
      check("fetch_ex_en", 32'(ex_en), 32'd0);
      cyc++;
      imem_ack = (k == w);
      imem_rdata = (k == w) ? instr : $urandom;
      decode_hata = 1'($urandom); execute_hata = 1'($urandom);
      branch_taken = 1'($urandom); pc_update = $urandom;
      if (k != w) m_stalls++;
      @(negedge clk);
      if (k == w) break;
      if (k == FT - 1) begin
        imem_ack = 1'b0;
        check_halt(2'd3);
        return;
      end
    end
    m_komut = instr;
    // DECODE: an ack here must not disturb the instruction register.
    check("dec_komut", komut, instr);
    check("dec_req", 32'(imem_req), 32'd0);
    check("dec_ex_en", 32'(ex_en), 32'd0);
    check("dec_we", 32'(we), 32'd0);
    cyc++;
    decode_hata = dec_e; execute_hata = 1'($urandom); branch_taken = 1'($urandom);
    pc_update = $urandom; imem_ack = 1'($urandom); imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 1'b0;
    if (dec_e) begin
      decode_hata = 1'b0;
      check_halt(2'd1);
      return;
    end
    // EXECUTE
    check("ex_en", 32'(ex_en), 32'd1);
    check("ex_we", 32'(we), 32'd0);
    check("ex_komut", komut, instr);
    check("ex_busy", 32'(busy), 32'd1);
    cyc++;
    execute_hata = ex_e; branch_taken = br; pc_update = tgt; decode_hata = 1'($urandom);
    if (abort_ex) begin
      #2 reset = 1'b0;
      model_reset();
      #1;
      check_reset_values("async");
      @(negedge clk);
      reset = 1'b1;
      return;
    end
    @(negedge clk);
    execute_hata = 1'b0; branch_taken = 1'b0; decode_hata = 1'b0;
    if (ex_e || (br && (tgt[1:0] != 2'b00))) begin
      check_halt(2'd2);
      return;
    end
    // WRITEBACK: PC still holds this instruction's address.
    check("wb_we", 32'(we), 32'd1);
    check("wb_ex_en", 32'(ex_en), 32'd0);
    check("wb_pc", pc, m_pc);
    cyc++;
    @(negedge clk);
    m_pc = br ? tgt : m_pc + 32'd4;
    m_retired++;
    check("latency", 32'(cyc), 32'(4 + w));
    check_perf("instr");
  endtask

  logic [31:0] t;

  initial begin
    do_reset();
    check("wrap_reset_pc", w_pc, 32'hFFFF_FFFC);

    // IDLE ignores ack and data.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    check("idle_komut", komut, 32'h0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b0;

    // Straight-line fetch of three instructions.
    start_run();
    for (int i = 0; i < 3; i++) run_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("straight_pc", pc, 32'd12);

    // Taken branch, wait cycles, ack in the last allowed cycle.
    run_instr(0, $urandom, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    check("branch_addr", imem_addr, 32'h40);
    run_instr(5, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_instr(FT - 1, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Random traffic: waits, aligned branches.
    for (int i = 0; i < 20; i++) begin
      t = $urandom;
      t[1:0] = 2'b00;
      run_instr(int'($urandom_range(0, 3)), $urandom, 1'b0, 1'b0, 1'($urandom), t, 1'b0);
    end

    // Misaligned branch target faults with code 2 and no writeback.
    run_instr(0, $urandom, 1'b0, 1'b0, 1'b1, 32'h42, 1'b0);

    // Decode error after one good instruction.
    do_reset();
    start_run();
    run_instr(1, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_instr(0, $urandom, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Fetch timeout: PC stays at the unfetched instruction.
    do_reset();
    start_run();
    run_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_instr(FT, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Execute error.
    do_reset();
    start_run();
    run_instr(2, $urandom, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of EXECUTE.
    do_reset();
    start_run();
    run_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    run_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // PC wrap on the second instance.
    t = 32'hFFFF_FFFC + 32'd4;
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    check("wrap_req", 32'(w_req), 32'd1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1;
    @(negedge clk);
    w_ack = 1'b0;
    check("wrap_komut", w_komut, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    check("wrap_we", 32'(w_we), 32'd1);
    @(negedge clk);
    check("wrap_pc", w_pc, t);
    check("wrap_addr1", w_addr, t);
    check("wrap_hata", 32'(w_hata), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/processor_sequencer.md
Name: processor_sequencer

Overview:
- Multi-cycle control FSM that sequences the existing fetch/decode/execute datapath of the processor.
- Fetches each instruction over a req/ack instruction-memory handshake and latches it as `komut`.
- Enables decode, execute and register-file writeback one phase at a time, and owns the PC register.
- Collects `hata` from decode, execute and fetch timeout, then halts stickily until reset.

Parameters:
- `XLEN`, 32: data/address width.
- `PC_RESET`, 32'h0000_0000: PC value after reset.
- `FETCH_TIMEOUT`, 16: max cycles `imem_req` may stay unacknowledged; must be ≥1.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: leave IDLE and begin fetching.
- `imem_req` output 1: instruction fetch request.
- `imem_addr` output XLEN: fetch address; always equals `pc`.
- `imem_ack` input 1: fetch data valid this cycle.
- `imem_rdata` input 32: fetched instruction.
- `komut` output 32: latched instruction register to decode.
- `decode_hata` input 1: decode error; sampled in DECODE only.
- `ex_en` output 1: execute stage enable.
- `execute_hata` input 1: execute error; sampled in EXECUTE only.
- `branch_taken` input 1: select `pc_update` as the next PC; sampled in EXECUTE.
- `pc_update` input XLEN: branch/jump target from execute.
- `we` output 1: register-file write enable, one-cycle pulse.
- `pc` output XLEN: current PC.
- `busy` output 1: FSM not in IDLE or HALT.
- `hata` output 1: sticky error flag.
- `hata_kod` output 2: 0 none, 1 decode, 2 execute/misaligned target, 3 fetch timeout.

Behaviour:
- Reset (async assert, `reset`=0):
  - state=IDLE, `pc`=`PC_RESET`, `komut`=0.
  - `imem_req`, `ex_en`, `we`, `busy`, `hata` all 0; `hata_kod`=0; timeout counter=0.
  - Deassertion is used synchronously.
  - Reset mid-operation aborts any outstanding fetch immediately; `imem_req` drops asynchronously.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT. The state encoding is visible only internally.
- IDLE:
  - `start`=1 → FETCH next cycle; otherwise stay.
  - `imem_ack` is ignored.
- FETCH:
  - `imem_req`=1 combinationally while in FETCH.
  - `imem_ack`=1 → `komut`<=`imem_rdata`, go to DECODE, clear the timeout counter.
  - Otherwise the counter increments. When the counter reaches `FETCH_TIMEOUT` without ack → HALT with `hata_kod`=3.
  - An ack in the same cycle as the timeout wins: the fetch completes.
- DECODE (1 cycle):
  - `decode_hata`=1 → HALT, `hata_kod`=1.
  - Else → EXECUTE.
- EXECUTE (1 cycle):
  - `ex_en`=1.
  - `execute_hata`=1, or (`branch_taken`=1 and `pc_update[1:0]`≠0) → HALT, `hata_kod`=2.
  - Else register the next PC and go to WRITEBACK.
  - Next PC = `pc_update` if `branch_taken`, else `pc`+4. Arithmetic is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
- WRITEBACK (1 cycle):
  - `we`=1.
  - `pc` <= registered next PC.
  - → FETCH.
- HALT:
  - `hata`=1; `busy`=0; no further `we` or `ex_en`.
  - `pc` frozen at the faulting instruction.
  - `start` is ignored; only reset exits.
- Error priority: only the phase's own error input is sampled; the other error inputs are don't-care. `hata_kod` is written once on entry to HALT.
- `we` is never asserted for an instruction that faults.
- Latency: 4 cycles per instruction with ack in the first FETCH cycle; +1 per wait cycle.
- Ack handling: `imem_ack` outside FETCH is ignored and produces no `komut` update.
- `busy`=1 in FETCH, DECODE, EXECUTE and WRITEBACK.

Optional Feature:
- Macro `PROC_SEQ_PERF_EN`.
- When defined, adds output ports:
  - `retired` (32): increments on each WRITEBACK cycle.
  - `stall_cycles` (32): increments on each FETCH cycle with `imem_req`=1 and `imem_ack`=0.
  - Both counters are cleared by reset and wrap modulo 2^32.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package `proc_seq_pkg`:
  - `state_t` enum.
  - `hata_kod_t` enum (NONE, DECODE, EXECUTE, TIMEOUT).
  - Constant `PC_STEP`=4.
- Sub-module `fetch_timer`:
  - Counter with clear/enable and a `timeout` output compared against `FETCH_TIMEOUT`.
  - Instantiated once.
- Everything else is in the top FSM.

Test Plan:
- Straight-line fetch:
  - Stimulus: `reset` low, release, `start`=1; ack every first FETCH cycle; 3 instructions.
  - Response: `pc` sequence 0,4,8,12; `we` pulses exactly on cycles 4, 8, 12 after `start`; `komut` matches `imem_rdata`.
- Taken branch:
  - Stimulus: `branch_taken`=1, `pc_update`=32'h40 in EXECUTE.
  - Response: next `imem_addr`=32'h40.
  - Stimulus: `pc_update`=32'h42.
  - Response: HALT, `hata`=1, `hata_kod`=2, no `we`.
- Fetch wait/timeout, with `FETCH_TIMEOUT`=16:
  - Stimulus: ack after 5 wait cycles.
  - Response: instruction takes 9 cycles.
  - Stimulus: no ack.
  - Response: HALT after 16 FETCH cycles, `hata_kod`=3, `pc` unchanged.
  - Stimulus: ack on cycle 16.
  - Response: fetch completes normally.
- Decode error:
  - Stimulus: `decode_hata`=1 in DECODE; then toggle `start`.
  - Response: HALT, `hata_kod`=1, `pc` held, `start` ignored; only reset clears.
- Async reset mid-EXECUTE:
  - Stimulus: pull `reset` low between clock edges.
  - Response: outputs return to reset values immediately; `ex_en` drops without a clock edge.
- Wrap and perf:
  - Stimulus: `PC_RESET`=32'hFFFF_FFFC, one instruction.
  - Response: next `pc`=0.
  - Stimulus: build with `PROC_SEQ_PERF_EN`, 3 instructions with 2 total wait cycles.
  - Response: `retired`=3, `stall_cycles`=2.
